// File: rtl/mau_instr_sequencer_if.sv
// Host <-> sequencer bundle for the MAU instruction sequencer.
//   master: host side (drives instr_in, instr_push, flush, mau_busy;
//           observes the sequencer status and the MAU instruction bus)
//   slave : sequencer side (the mirror image)
// DEPTH must match the DEPTH of the sequencer instance, it sizes count.
interface mau_instr_sequencer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    instr_in;
  logic          instr_push;
  logic          flush;
  logic          mau_busy;
  logic [7:0]    mau_instruction;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          op_done;
  logic [7:0]    done_instr;
  logic          idle;
  logic          overflow;
  logic          timeout;

  modport master (
    output instr_in, instr_push, flush, mau_busy,
    input  mau_instruction, full, empty, count, op_done, done_instr,
           idle, overflow, timeout
  );

  modport slave (
    input  instr_in, instr_push, flush, mau_busy,
    output mau_instruction, full, empty, count, op_done, done_instr,
           idle, overflow, timeout
  );
endinterface

// File: rtl/mau_instr_sequencer.sv
// MAU instruction sequencer: queues host instructions in a circular FIFO and
// issues them one at a time to the MAU, tracking its busy flag to detect
// completion (or a missing busy response, reported as a timeout).
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mau_instr_sequencer_if.slave: instr_in/instr_push/flush/mau_busy in;
//          mau_instruction, full, empty, count, op_done, done_instr, idle,
//          overflow, timeout out
module mau_instr_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter int unsigned BUSY_WAIT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mau_instr_sequencer_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMAX = (ISSUE_CYCLES > BUSY_WAIT) ? ISSUE_CYCLES : BUSY_WAIT;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ISSUE_LAST = TW'(ISSUE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, next_state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    cur_instr;
  logic          busy_seen;
  logic [TW-1:0] timer;
  logic          op_done_r;
  logic [7:0]    done_instr_r;
  logic          overflow_r;
  logic          timeout_r;

  logic          q_full, q_empty;
  logic [7:0]    head;
  logic          push_ok, push_drop;
  logic          pop, finish, finish_timeout;

  // Queue status and push qualification. Fullness is judged before any
  // same-cycle pop, so a push against a full queue is always dropped.
  always_comb begin
    q_full    = (count == CW'(DEPTH));
    q_empty   = (count == '0);
    head      = mem[rd_ptr];
    push_ok   = bus.instr_push && !bus.flush && !q_full;
    push_drop = bus.instr_push && !bus.flush && q_full;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A NOP head is popped in IDLE without leaving IDLE.
  always_comb begin
    next_state     = state;
    pop            = 1'b0;
    finish         = 1'b0;
    finish_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && !bus.mau_busy) begin
          pop = 1'b1;
          if (head != 8'h00) next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (timer == ISSUE_LAST)
          next_state = (busy_seen || bus.mau_busy) ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.mau_busy) begin
          next_state = WAIT_DONE;
        end else if (timer == WAIT_LAST) begin
          next_state     = IDLE;
          finish         = 1'b1;
          finish_timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.mau_busy) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Queue storage; no reset needed, entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.instr_in;
  end

  // Datapath: queue pointers, current instruction, phase timer, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cur_instr    <= '0;
      busy_seen    <= 1'b0;
      timer        <= '0;
      op_done_r    <= 1'b0;
      done_instr_r <= '0;
      overflow_r   <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      // A pop coinciding with flush still hands its entry to the FSM;
      // flush only discards what remains queued.
      if (bus.flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (push_drop) overflow_r <= 1'b1;
      end

      if (pop && head != 8'h00) cur_instr <= head;

      busy_seen <= (state == ISSUE) ? (busy_seen | bus.mau_busy) : 1'b0;

      // Timer restarts on every state change; only ISSUE and WAIT_BUSY use it.
      if (next_state == state && (state == ISSUE || state == WAIT_BUSY))
        timer <= timer + 1'b1;
      else
        timer <= '0;

      op_done_r <= finish;
      if (finish)         done_instr_r <= cur_instr;
      if (finish_timeout) timeout_r    <= 1'b1;
    end
  end

  // Outputs
  always_comb begin
    bus.mau_instruction = (state == ISSUE) ? cur_instr : 8'h00;
    bus.full            = q_full;
    bus.empty           = q_empty;
    bus.count           = count;
    bus.op_done         = op_done_r;
    bus.done_instr      = done_instr_r;
    bus.idle            = (state == IDLE) && q_empty && !bus.mau_busy;
    bus.overflow        = overflow_r;
    bus.timeout         = timeout_r;
  end
endmodule

// File: doc/mau_instr_sequencer.md
MAU_INSTR_SEQUENCER -- requirements
Module: mau_instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: instruction queue depth; power of 2, at least 2.
REQ-002 Parameter ISSUE_CYCLES, default 2: cycles an instruction is driven to the MAU.
REQ-003 Parameter BUSY_WAIT, default 4: cycles allowed after issue ends for MAU busy to rise.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instr_in  input  8  host instruction: [7:6] dest BRAM, [5:4] src BRAM, [3:0] opcode.
REQ-007 instr_push  input  1  enqueue instr_in this cycle.
REQ-008 flush  input  1  discard all queued, not-yet-issued instructions.
REQ-009 mau_busy  input  1  MAU busy_flag.
REQ-010 mau_instruction  output  8  drives MAU host_instruction.
REQ-011 full  output  1  queue holds DEPTH entries.
REQ-012 empty  output  1  queue holds 0 entries.
REQ-013 count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-014 op_done  output  1  one-cycle pulse when an issued instruction completes.
REQ-015 done_instr  output  8  instruction that completed; valid while op_done is high, held otherwise.
REQ-016 idle  output  1  FSM in IDLE, queue empty and mau_busy low.
REQ-017 overflow  output  1  sticky: a push was dropped.
REQ-018 timeout  output  1  sticky: an issued instruction never raised mau_busy.

Function
REQ-019 Queue: FIFO with circular read/write pointers; entries issue in push order; pointers wrap modulo DEPTH.
REQ-020 A push while full is dropped and sets overflow; this holds even if a pop occurs in the same cycle.
REQ-021 A push while not full is stored, including when a pop occurs in the same cycle; count is unchanged in that case.
REQ-022 flush empties the queue next cycle (count=0) and clears overflow; an in-flight instruction is not aborted; a push in the same cycle as flush is dropped without setting overflow.
REQ-023 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE: when the queue is non-empty and mau_busy=0, pop the head into a current-instruction register and go to ISSUE.
REQ-025 IDLE with a head entry equal to 8'h00 (NOP): pop it and discard it; stay in IDLE; no op_done.
REQ-026 ISSUE: mau_instruction = current instruction for exactly ISSUE_CYCLES cycles; mau_instruction = 8'h00 in every other state.
REQ-027 During ISSUE, a busy_seen flag is set if mau_busy=1.
REQ-028 Leaving ISSUE: go to WAIT_DONE if busy_seen or mau_busy=1; otherwise go to WAIT_BUSY.
REQ-029 WAIT_BUSY: go to WAIT_DONE on the first cycle mau_busy=1.
REQ-030 WAIT_BUSY: if mau_busy stays 0 for BUSY_WAIT cycles, pulse op_done, set timeout, and return to IDLE.
REQ-031 WAIT_DONE: on the first cycle mau_busy=0, pulse op_done with done_instr = current instruction and return to IDLE.
REQ-032 Minimum issue-to-issue spacing is ISSUE_CYCLES+2 cycles; back-to-back instructions never overlap.
REQ-033 Bit fields are not decoded except for the NOP check; LOAD/UNLOAD data streaming remains the host's job while mau_busy is high.

Reset
REQ-034 Asserting rst forces the following, regardless of FSM state and including mid-operation:
- state IDLE
- queue empty, count=0, full=0, empty=1
- mau_instruction=8'h00
- op_done=0, done_instr=8'h00
- overflow=0, timeout=0, busy_seen=0
- idle=1 once mau_busy is low

Verification
REQ-035 After reset, push 8'h0C (ADD); model holds busy 3 cycles starting 1 cycle after issue -> mau_instruction=8'h0C for 2 cycles then 8'h00; op_done pulses once with done_instr=8'h0C; idle=1 afterwards.
REQ-036 Push 8'h04, 8'h00, 8'h07 -> issued sequence is 8'h04 then 8'h07; 8'h00 is never driven as an issue; exactly 2 op_done pulses.
REQ-037 Model never raises busy; push 8'h05 -> op_done 2+4 cycles after issue starts; timeout=1 and stays 1 until reset.
REQ-038 Hold mau_busy high; push 9 entries with DEPTH=8 -> full=1, count=8, overflow=1; 9th entry lost; after release, entries drain in order with wrap-around.
REQ-039 Full queue plus simultaneous push and pop -> push dropped, overflow=1. Queue of count 3 plus simultaneous push and pop -> count stays 3.
REQ-040 Flush mid-WAIT_DONE with 4 queued entries -> count=0; current op still completes with one op_done. Then assert rst during ISSUE -> mau_instruction=8'h00 immediately, all flags clear.
